image_uart_tx: RTL and testbench
================================

Name: image_uart_tx

Overview:
Reader side of the equalized-image buffer. After the processor has written the equalized image into data memory, this block walks the buffer one word at a time and reads it through a synchronous-read port. It serializes the low byte of each word onto a UART TX line (8N1, LSB first) so the image can be captured on a host PC. It sits beside dmem in the top level and uses a second read port of the memory.

Parameters:
BAUD_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
ADDR_W, 18, width of the word address into the image buffer
NUM_PIXELS, 262144, number of words to transmit (512x512); legal range 1..2^ADDR_W
BASE_ADR, 0, word address of the first pixel

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a full image transfer
mem_adr  out  ADDR_W  word address presented to the memory read port
mem_rd  out  1  read strobe to the memory
mem_data  in  32  read data; valid exactly 1 cycle after mem_rd is high
tx  out  1  UART serial output, idle high
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the stop bit of the last pixel
pix_idx  out  ADDR_W  index of the pixel currently being sent (0-based)

Behaviour:
- Reset (reset=0, async): state=IDLE, tx=1, busy=0, done=0, mem_rd=0, mem_adr=BASE_ADR, pix_idx=0, baud counter=0.
- The FSM has seven states: IDLE, FETCH, LOAD, START, DATA, STOP, NEXT.
- IDLE: start=1 -> FETCH; pix_idx=0, mem_adr=BASE_ADR, busy=1 on the next edge. start is ignored in every other state.
- FETCH: mem_rd=1 for one cycle -> LOAD.
- LOAD: shift register <= mem_data[7:0]; upper 24 bits ignored -> START.
- START: tx=0 for BAUD_DIV cycles -> DATA.
- DATA: tx=shift[0]; after each BAUD_DIV cycles, shift right and increment the bit count. After the 8th bit -> STOP.
- STOP: tx=1 for BAUD_DIV cycles. If pix_idx==NUM_PIXELS-1 -> IDLE with done=1 for one cycle and busy=0. Otherwise -> NEXT.
- NEXT: pix_idx+1, mem_adr+1 -> FETCH.
- Inter-frame gap is 3 cycles (NEXT, FETCH, LOAD) with tx held high.
- Frame length is 10*BAUD_DIV cycles, plus BAUD_DIV for the parity bit when enabled.
- Baud counter counts 0..BAUD_DIV-1 and reloads to 0 on every state change.
- tx is driven from a register (glitch-free). It is 1 in all states except START and DATA.
- mem_adr wraps modulo 2^ADDR_W; BASE_ADR+NUM_PIXELS beyond the range is permitted and wraps.
- start and done coincide only if start arrives in the done cycle. It is accepted then because the FSM is already in IDLE.
- Reset mid-frame: tx returns to 1 immediately. No partial stop bit is generated and the transfer is abandoned.
- mem_data is sampled only in LOAD; changes at any other time have no effect.

Optional Feature:
IMG_TX_PARITY_EN
- Defined: a PARITY state sits between DATA and STOP and drives the even parity of the 8 data bits (XOR of the bits) for BAUD_DIV cycles. Frame is 11 bits.
- Undefined: no PARITY state, 8N1 frame. Resource use and timing are identical to the base design.

Test Plan:
- BAUD_DIV=4, NUM_PIXELS=1, mem word 0 = 0x000000A5; pulse start. Required:
  - tx low for 4 cycles, then 1,0,1,0,0,1,0,1 with 4 cycles each, then high for 4 cycles.
  - done pulses once; busy is high throughout and low after done.
- BAUD_DIV=4, NUM_PIXELS=3, words 0x11,0x22,0x33 at BASE_ADR=5. Required:
  - mem_rd asserts at addresses 5, 6, 7 in order.
  - Decoded bytes are 0x11, 0x22, 0x33.
  - Exactly 3 high cycles between each stop bit and the next start bit.
- Upper bits ignored: word 0xFFFFFF00 -> transmitted byte 0x00.
- Pulse start again in the middle of the second frame. Required: no restart, pix_idx is unaffected, and exactly 3 bytes are sent.
- Assert reset during DATA of byte 1. Required:
  - tx=1 asynchronously and busy=0.
  - A following start re-sends from BASE_ADR, pix_idx=0.
- With IMG_TX_PARITY_EN, word 0x07 -> parity bit 1 after the data bits; word 0x03 -> parity bit 0. Frame is 44 cycles at BAUD_DIV=4.

Source files
------------

// File: rtl/image_uart_tx.sv
// Image buffer reader: fetches each word through a synchronous-read port and sends its low byte
// as an 8N1 UART frame, LSB first. Define IMG_TX_PARITY_EN for an even-parity bit (8E1 frame).
module image_uart_tx #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned NUM_PIXELS = 262144,
  parameter int unsigned BASE_ADR   = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic              mem_rd_o,
  input  logic [31:0]       mem_data_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] pix_idx_o
);

  localparam logic [15:0]       BaudLast = 16'(BAUD_DIV - 1);
  localparam logic [ADDR_W-1:0] AdrBase  = ADDR_W'(BASE_ADR);
  localparam logic [ADDR_W-1:0] PixLast  = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StData,
`ifdef IMG_TX_PARITY_EN
    StParity,
`endif
    StStop,
    StNext
  } state_e;

  state_e            state_q;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q, busy_q, done_q, rd_q;
  logic [ADDR_W-1:0] adr_q, pix_q;
  logic              bit_end;
`ifdef IMG_TX_PARITY_EN
  logic              par_q;
`endif

  // Only the low byte of each word is transmitted.
  logic unused_hi;
  assign unused_hi = ^mem_data_i[31:8];

  always_comb begin
    bit_end = (cnt_q == BaudLast);
    cnt_d   = bit_end ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      adr_q   <= AdrBase;
      pix_q   <= '0;
`ifdef IMG_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StFetch;
            pix_q   <= '0;
            adr_q   <= AdrBase;
            busy_q  <= 1'b1;
            rd_q    <= 1'b1;
          end
        end
        StFetch: state_q <= StLoad;
        StLoad: begin
          shift_q <= mem_data_i[7:0];
`ifdef IMG_TX_PARITY_EN
          par_q   <= ^mem_data_i[7:0];
`endif
          tx_q    <= 1'b0;
          state_q <= StStart;
        end
        StStart: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q <= StData;
            tx_q    <= shift_q[0];
            bit_q   <= '0;
          end
        end
        StData: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (bit_q == 3'd7) begin
`ifdef IMG_TX_PARITY_EN
              state_q <= StParity;
              tx_q    <= par_q;
`else
              state_q <= StStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end
        end
`ifdef IMG_TX_PARITY_EN
        StParity: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q <= StStop;
            tx_q    <= 1'b1;
          end
        end
`endif
        StStop: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (pix_q == PixLast) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StNext;
            end
          end
        end
        StNext: begin
          pix_q   <= pix_q + 1'b1;
          adr_q   <= adr_q + 1'b1;
          rd_q    <= 1'b1;
          state_q <= StFetch;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_adr_o = adr_q;
  assign mem_rd_o  = rd_q;
  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pix_idx_o = pix_q;

endmodule

// File: tb/tb_image_uart_tx.sv
// Bench for image_uart_tx: table of image words, UART frame decoder with a byte scoreboard,
// plus hand-written sequences for mid-transfer start and reset.
module tb_image_uart_tx;

  localparam int unsigned BAUD   = 4;
  localparam int unsigned ADDR_W = 18;
  localparam int unsigned NPIX   = 3;
  localparam int unsigned BASE   = 5;
`ifdef IMG_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int FRAME = FBITS * BAUD;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] mem_adr, pix_idx;
  logic              mem_rd, tx, busy, done;
  logic [31:0]       mem_data;
  logic [31:0]       mem [0:15];

  int checks = 0;
  int errors = 0;
  int frames = 0;
  int done_cnt = 0;
  logic [7:0]  exp_q[$];
  int unsigned rd_log[$];

  typedef struct {
    logic [31:0] word;
    logic [7:0]  byte_exp;
  } vec_t;
  vec_t vecs [9];

  image_uart_tx #(
    .BAUD_DIV  (BAUD),
    .ADDR_W    (ADDR_W),
    .NUM_PIXELS(NPIX),
    .BASE_ADR  (BASE)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .mem_adr_o (mem_adr),
    .mem_rd_o  (mem_rd),
    .mem_data_i(mem_data),
    .tx_o      (tx),
    .busy_o    (busy),
    .done_o    (done),
    .pix_idx_o (pix_idx)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; garbage on the bus whenever no read was issued.
  always @(posedge clk) mem_data <= mem_rd ? mem[mem_adr[3:0]] : $urandom;

  always @(negedge clk) if (mem_rd && rst_n) rd_log.push_back(32'(mem_adr));
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // UART decoder: samples every cycle of a frame and scores the byte.
  initial begin : monitor
    logic       s [0:FRAME-1];
    logic [7:0] b;
    logic       stable, ab, got_low;
    int         gap;
    got_low = 1'b0;
    forever begin
      if (!got_low) begin
        @(negedge clk);
        while (!(tx === 1'b0 && rst_n)) @(negedge clk);
      end
      got_low = 1'b0;
      ab = 1'b0;
      s[0] = 1'b0;
      for (int c = 1; c < FRAME; c++) begin
        @(negedge clk);
        if (!rst_n) begin
          ab = 1'b1;
          break;
        end
        s[c] = tx;
      end
      if (!ab) begin
        stable = 1'b1;
        for (int c = 0; c < FRAME; c++) if (s[c] !== s[(c / BAUD) * BAUD]) stable = 1'b0;
        check("bit_stable", 32'(stable), 1);
        for (int i = 0; i < 8; i++) b[i] = s[(i + 1) * BAUD];
        check("stop_bit", 32'(s[(FBITS - 1) * BAUD]), 1);
`ifdef IMG_TX_PARITY_EN
        check("parity_bit", 32'(s[9 * BAUD]), 32'(^b));
`endif
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL byte_unexpected: got %02h want none", b);
        end else begin
          check("byte", 32'(b), 32'(exp_q.pop_front()));
        end
        frames++;
        gap = 0;
        while (gap < 16) begin
          @(negedge clk);
          if (tx === 1'b0 && rst_n) begin
            got_low = 1'b1;
            break;
          end
          gap++;
        end
        if (got_low) check("frame_gap", 32'(gap), 3);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_words(input int first);
    for (int i = 0; i < int'(NPIX); i++) begin
      mem[BASE + i] = vecs[first + i].word;
      exp_q.push_back(vecs[first + i].byte_exp);
    end
  endtask

  task automatic run_xfer(input int first, input bit mid_start);
    int wait_c, busy_drop, d0, f0, since;
    load_words(first);
    rd_log.delete();
    d0 = done_cnt;
    f0 = frames;
    busy_drop = 0;
    since = 0;
    @(negedge clk);
    pulse_start();
    check("busy_after_start", 32'(busy), 1);
    check("pix_idx_start", 32'(pix_idx), 0);
    wait_c = 0;
    while (!done && wait_c < 400) begin
      if (!busy) busy_drop++;
      if (mid_start && pix_idx == 1) begin
        since++;
        if (since == 20) begin
          pulse_start();
          wait_c++;
          check("pix_idx_mid_start", 32'(pix_idx), 1);
        end
      end
      if (!done) begin
        @(negedge clk);
        wait_c++;
      end
    end
    check("done_seen", 32'(done), 1);
    check("busy_at_done", 32'(busy), 0);
    check("busy_held", 32'(busy_drop), 0);
    check("pix_idx_last", 32'(pix_idx), NPIX - 1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("done_count", 32'(done_cnt - d0), 1);
    check("frames_sent", 32'(frames - f0), NPIX);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    check("mem_rd_count", 32'(rd_log.size()), NPIX);
    for (int i = 0; i < rd_log.size() && i < int'(NPIX); i++)
      check("mem_rd_adr", rd_log[i], BASE + i);
    repeat (20) @(negedge clk);
  endtask

  initial begin : test
    int wait_c;
    vecs[0] = '{32'h0000_00A5, 8'hA5};
    vecs[1] = '{32'hFFFF_FF00, 8'h00};
    vecs[2] = '{32'h1234_563C, 8'h3C};
    vecs[3] = '{32'h0000_0011, 8'h11};
    vecs[4] = '{32'h0000_0022, 8'h22};
    vecs[5] = '{32'h0000_0033, 8'h33};
    vecs[6] = '{32'h0000_0007, 8'h07};
    vecs[7] = '{32'h0000_0003, 8'h03};
    vecs[8] = '{32'hABCD_EF80, 8'h80};
    for (int i = 0; i < 16; i++) mem[i] = '0;

    @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_adr", 32'(mem_adr), BASE);
    check("rst_pix_idx", 32'(pix_idx), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int t = 0; t < 3; t++) run_xfer(t * 3, t == 1);

    // Reset while the second pixel is in its data bits.
    load_words(6);
    pulse_start();
    wait_c = 0;
    while (pix_idx != 1 && wait_c < 200) begin
      @(negedge clk);
      wait_c++;
    end
    check("reached_pixel1", 32'(pix_idx), 1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx), 1);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_pix_idx", 32'(pix_idx), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (5) @(negedge clk);
    run_xfer(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
